ahb_uart_lite: RTL

AHB_UART_LITE -- requirements
Module: ahb_uart_lite

---
 rtl/ahb_uart_lite.sv | 314 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/ahb_uart_lite.sv
// AHB-Lite UART: TX FIFO with an 8N1 transmitter, and a single-byte 8N1 receiver.
// Ports: CLK/RST, AHB-Lite slave (HSEL..HRESP), TXD/RXD serial lines, IRQ level out.
module ahb_uart_lite #(
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16,
  parameter int DIV_RESET  = 867
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic [31:0] HRDATA,
  output logic        HRESP,
  output logic        TXD,
  input  logic        RXD,
  output logic        IRQ
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {
    TX_IDLE, TX_START, TX_DATA, TX_STOP
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP
  } rx_state_t;

  logic unused_bits;
  assign unused_bits = ^{HSIZE, HADDR[31:4], HADDR[1:0],
                         HTRANS[0], HWDATA};

  // bus address phase
  logic       act_q;
  logic       wr_q;
  logic [1:0] addr_q;
  logic       addr_phase;

  assign addr_phase = HSEL & HREADY & HTRANS[1];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      act_q  <= 1'b0;
      wr_q   <= 1'b0;
      addr_q <= 2'd0;
    end else begin
      act_q <= addr_phase;
      if (addr_phase) begin
        addr_q <= HADDR[3:2];
        wr_q   <= HWRITE;
      end
    end
  end

  logic wr_data, rd_data, rd_stat, wr_div;

  assign wr_data = act_q & wr_q & (addr_q == 2'd0);
  assign rd_data = act_q & ~wr_q & (addr_q == 2'd0);
  assign rd_stat = act_q & ~wr_q & (addr_q == 2'd1);
  assign wr_div  = act_q & wr_q & (addr_q == 2'd2);

  // divisor
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] eff_div;
  logic [DIV_W:0]   eff_p1;
  logic [DIV_W-1:0] rx_half;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) div_q <= DIV_W'(DIV_RESET);
    else if (wr_div) div_q <= HWDATA[DIV_W-1:0];
  end

  assign eff_div = (div_q < DIV_W'(3)) ? DIV_W'(3) : div_q;
  assign eff_p1  = {1'b0, eff_div} + (DIV_W+1)'(1);
  // counts down to 0, so load one less than half a bit
  assign rx_half = eff_p1[DIV_W:1] - DIV_W'(1);

  // TX FIFO
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          tx_full, tx_empty, push, tx_pop;
  tx_state_t     tx_state;
  logic [DIV_W-1:0] tx_cnt;

  assign tx_full  = (count == (AW+1)'(FIFO_DEPTH));
  assign tx_empty = (count == '0);
  // full is judged before any same-cycle pop
  assign push     = wr_data & ~tx_full;
  assign tx_pop   = ~tx_empty &
                    ((tx_state == TX_IDLE) |
                     ((tx_state == TX_STOP) & (tx_cnt == '0)));

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= HWDATA[7:0];
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (tx_pop) rd_ptr <= rd_ptr + AW'(1);
      if (push & ~tx_pop) count <= count + (AW+1)'(1);
      else if (~push & tx_pop) count <= count - (AW+1)'(1);
    end
  end

  // transmitter
  logic [7:0] tx_sh;
  logic [2:0] tx_idx;
  logic       txd_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_sh    <= '0;
      tx_idx   <= '0;
      txd_q    <= 1'b1;
    end else begin
      unique case (tx_state)
        TX_IDLE: begin
          if (tx_pop) begin
            tx_sh    <= mem[rd_ptr];
            txd_q    <= 1'b0;
            tx_cnt   <= eff_div;
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (tx_cnt == '0) begin
            txd_q    <= tx_sh[0];
            tx_sh    <= tx_sh >> 1;
            tx_idx   <= '0;
            tx_cnt   <= eff_div;
            tx_state <= TX_DATA;
          end else begin
            tx_cnt <= tx_cnt - DIV_W'(1);
          end
        end
        TX_DATA: begin
          if (tx_cnt == '0) begin
            tx_cnt <= eff_div;
            if (tx_idx == 3'd7) begin
              txd_q    <= 1'b1;
              tx_state <= TX_STOP;
            end else begin
              txd_q  <= tx_sh[0];
              tx_sh  <= tx_sh >> 1;
              tx_idx <= tx_idx + 3'd1;
            end
          end else begin
            tx_cnt <= tx_cnt - DIV_W'(1);
          end
        end
        TX_STOP: begin
          if (tx_cnt == '0) begin
            // chain straight into the next start bit
            if (tx_pop) begin
              tx_sh    <= mem[rd_ptr];
              txd_q    <= 1'b0;
              tx_cnt   <= eff_div;
              tx_state <= TX_START;
            end else begin
              tx_state <= TX_IDLE;
            end
          end else begin
            tx_cnt <= tx_cnt - DIV_W'(1);
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // receiver
  logic rx_s1, rx_s2, rx_prev;
  rx_state_t rx_state;
  logic [DIV_W-1:0] rx_cnt;
  logic [7:0] rx_sh;
  logic [2:0] rx_idx;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= RXD;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_sh    <= '0;
      rx_idx   <= '0;
    end else begin
      unique case (rx_state)
        RX_IDLE: begin
          if (rx_prev & ~rx_s2) begin
            rx_cnt   <= rx_half;
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (rx_cnt == '0) begin
            if (rx_s2) begin
              rx_state <= RX_IDLE;
            end else begin
              rx_cnt   <= eff_div;
              rx_idx   <= '0;
              rx_state <= RX_DATA;
            end
          end else begin
            rx_cnt <= rx_cnt - DIV_W'(1);
          end
        end
        RX_DATA: begin
          if (rx_cnt == '0) begin
            rx_sh  <= {rx_s2, rx_sh[7:1]};
            rx_cnt <= eff_div;
            if (rx_idx == 3'd7) rx_state <= RX_STOP;
            else rx_idx <= rx_idx + 3'd1;
          end else begin
            rx_cnt <= rx_cnt - DIV_W'(1);
          end
        end
        RX_STOP: begin
          if (rx_cnt == '0) rx_state <= RX_IDLE;
          else rx_cnt <= rx_cnt - DIV_W'(1);
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  logic rx_done_ok, rx_done_bad;

  assign rx_done_ok  = (rx_state == RX_STOP) & (rx_cnt == '0) & rx_s2;
  assign rx_done_bad = (rx_state == RX_STOP) & (rx_cnt == '0) & ~rx_s2;

  // status flags
  logic [7:0] rx_data;
  logic       rx_valid, rx_overrun, rx_frame_err, tx_drop;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
      tx_drop      <= 1'b0;
    end else begin
      if (rd_stat) begin
        rx_overrun   <= 1'b0;
        rx_frame_err <= 1'b0;
        tx_drop      <= 1'b0;
      end
      // a byte landing during a DATA read replaces the one being read
      if (rx_done_ok) begin
        if (rx_valid & ~rd_data) begin
          rx_overrun <= 1'b1;
        end else begin
          rx_data  <= rx_sh;
          rx_valid <= 1'b1;
        end
      end else if (rd_data) begin
        rx_valid <= 1'b0;
      end
      if (rx_done_bad) rx_frame_err <= 1'b1;
      if (wr_data & tx_full) tx_drop <= 1'b1;
    end
  end

  // read mux
  logic [8:0]  cnt9;
  logic [31:0] status;

  assign cnt9   = 9'(count);
  assign status = {16'd0, cnt9[7:0], 1'b0, rx_frame_err, tx_drop,
                   (tx_state != TX_IDLE), rx_overrun, rx_valid,
                   tx_empty, tx_full};

  always_comb begin
    HRDATA = '0;
    if (act_q & ~wr_q) begin
      unique case (addr_q)
        2'd0:    HRDATA = {24'd0, rx_data};
        2'd1:    HRDATA = status;
        2'd2:    HRDATA = 32'(div_q);
        default: HRDATA = '0;
      endcase
    end
  end

  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;
  assign TXD       = txd_q;
  assign IRQ       = rx_valid | rx_overrun | rx_frame_err;

endmodule
